// File: rtl/spike_event_scheduler.sv
// Event scheduler for the time-multiplexed neuron datapath: queues external and
// recurrent spikes, and sequences accumulate sweeps per event and update sweeps per timestep.
module spike_event_scheduler #(
    parameter int unsigned NR_DEPTH         = 16,
    parameter int unsigned SR_DEPTH         = 16384,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned REC_BASE         = SR_DEPTH - NR_DEPTH,
    parameter int unsigned MAX_NETWORK_TIME = 65536
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                step,
    input  logic                                input_occurred,
    input  logic [$clog2(SR_DEPTH)-1:0]         input_index,
    input  logic                                fire,
    output logic                                input_ack,
    output logic [$clog2(NR_DEPTH)-1:0]         c_neuron_index,
    output logic [$clog2(SR_DEPTH)-1:0]         c_synapse_index,
    output logic                                c_neuron_we,
    output logic                                c_accumulate,
    output logic                                output_occurred,
    output logic [$clog2(NR_DEPTH)-1:0]         output_index,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    output logic [$clog2(MAX_NETWORK_TIME)-1:0] time_count
);

    localparam int unsigned NW = $clog2(NR_DEPTH);
    localparam int unsigned SW = $clog2(SR_DEPTH);
    localparam int unsigned TW = $clog2(MAX_NETWORK_TIME);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [NW-1:0] LAST_NEURON = NW'(NR_DEPTH - 1);
    localparam logic [PW-1:0] LAST_SLOT   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [TW:0]   TIME_LIMIT  = (TW + 1)'(MAX_NETWORK_TIME);
    localparam logic [SW-1:0] REC_ID_BASE = SW'(REC_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ACCUM,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   nidx_q, nidx_d;
    logic [SW-1:0]   src_q, src_d;
    logic [TW-1:0]   time_q, time_d;
    logic            ovf_q, ovf_d;
    logic            pend_q, pend_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, acc_q, busy_q, done_q;

    logic [SW-1:0]   mem_q [FIFO_DEPTH];

    logic            fifo_full, fifo_empty, last_neuron;
    logic            in_window, rec_fire;
    logic            push, pop, clear;
    logic [SW-1:0]   push_data;
    logic [TW:0]     time_inc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full   = (cnt_q == FULL_COUNT);
    assign fifo_empty  = (cnt_q == '0);
    assign last_neuron = (nidx_q == LAST_NEURON);
    assign in_window   = (state_q == S_RUN) || (state_q == S_ACCUM);
    assign rec_fire    = fire && (state_q == S_UPDATE);
    assign time_inc    = {1'b0, time_q} + 1'b1;

    // External and recurrent pushes live in disjoint states, so one write port suffices.
    assign input_ack = input_occurred && in_window && !fifo_full;
    assign push      = input_ack || (rec_fire && !fifo_full);
    assign push_data = input_ack ? input_index : REC_ID_BASE + SW'(nidx_q);
    assign pop       = (state_q == S_RUN) && !fifo_empty;

    always_comb begin
        state_d = state_q;
        nidx_d  = nidx_q;
        src_d   = src_q;
        time_d  = time_q;
        ovf_d   = ovf_q || (rec_fire && fifo_full);
        pend_d  = pend_q;
        clear   = 1'b0;

        if (step && (in_window || state_q == S_UPDATE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    time_d  = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                if (!fifo_empty) begin
                    src_d   = mem_q[rd_q];
                    state_d = S_ACCUM;
                end else if (pend_q) begin
                    // Clearing on entry wins over a coincident step: both belong to this timestep.
                    pend_d  = 1'b0;
                    state_d = S_UPDATE;
                end
            end
            S_ACCUM: begin
                if (last_neuron) begin
                    nidx_d  = '0;
                    state_d = S_RUN;
                end else begin
                    nidx_d = nidx_q + 1'b1;
                end
            end
            S_UPDATE: begin
                if (last_neuron) begin
                    nidx_d  = '0;
                    time_d  = time_inc[TW-1:0];
                    state_d = (time_inc == TIME_LIMIT) ? S_DONE : S_RUN;
                end else begin
                    nidx_d = nidx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            nidx_q  <= '0;
            src_q   <= '0;
            time_q  <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nidx_q  <= nidx_d;
            src_q   <= src_d;
            time_q  <= time_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            we_q    <= (state_d == S_ACCUM) || (state_d == S_UPDATE);
            acc_q   <= (state_d == S_ACCUM);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign c_neuron_index  = nidx_q;
    assign c_synapse_index = acc_q ? src_q : '0;
    assign c_neuron_we     = we_q;
    assign c_accumulate    = acc_q;
    assign output_occurred = rec_fire;
    assign output_index    = nidx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overflow        = ovf_q;
    assign time_count      = time_q;

endmodule

// File: doc/spike_event_scheduler.md
Name: spike_event_scheduler

Overview:
Sequencing controller for the time-multiplexed neuron datapath: the neuron-state SRAM, the synapse SRAM, the neuron accumulator and the neuron processor. It buffers external input spikes and recurrent (fired-neuron) spikes in an event FIFO. For each event it runs an accumulate sweep over all neurons. On each timestep strobe it runs an update sweep. It drives the SRAM address, write-enable and accumulate/process select, and counts network time.

Parameters:
NR_DEPTH, 16, number of neurons (one neuron visited per sweep cycle)
SR_DEPTH, 16384, number of synapse rows; one row per presynaptic source id
FIFO_DEPTH, 16, event FIFO entries; must be >= NR_DEPTH
REC_BASE, SR_DEPTH-NR_DEPTH, source id of neuron 0's recurrent spike; neuron n uses REC_BASE+n
MAX_NETWORK_TIME, 65536, number of timesteps per run

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  run-start pulse
step  in  1  end-of-timestep strobe
input_occurred  in  1  external spike request
input_index  in  clog2(SR_DEPTH)  external spike source id
fire  in  1  spike flag from neuron processor for current c_neuron_index
input_ack  out  1  request accepted this cycle
c_neuron_index  out  clog2(NR_DEPTH)  neuron SRAM address
c_synapse_index  out  clog2(SR_DEPTH)  synapse SRAM address (event source id)
c_neuron_we  out  1  neuron SRAM write enable
c_accumulate  out  1  1 = write accumulator result, 0 = write processor result
output_occurred  out  1  neuron fired this cycle
output_index  out  clog2(NR_DEPTH)  index of firing neuron
busy  out  1  state is not IDLE or DONE
done  out  1  run complete
overflow  out  1  sticky: a recurrent event was dropped
time_count  out  clog2(MAX_NETWORK_TIME)  current timestep

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, FIFO empty, step_pending=0. All outputs 0.
- SRAM read is combinational and write is synchronous, so one neuron is processed per cycle. Each sweep lasts exactly NR_DEPTH cycles, visiting c_neuron_index 0..NR_DEPTH-1.
- States:
  - IDLE: start -> RUN. On start: time_count=0, overflow=0, FIFO cleared.
  - RUN: if FIFO non-empty, pop the head into a src register and go to ACCUM. Otherwise, if step_pending=1, go to UPDATE. Otherwise stay. FIFO has priority over step_pending.
  - ACCUM: c_neuron_we=1, c_accumulate=1, c_synapse_index=src. After the last neuron, return to RUN.
  - UPDATE: step_pending is cleared on entry. c_neuron_we=1, c_accumulate=0. After the last neuron, time_count+1. If the new value equals MAX_NETWORK_TIME, go to DONE; otherwise go to RUN.
  - DONE: done=1. Hold until start, which behaves as in IDLE.
- Outside ACCUM and UPDATE: c_neuron_we=0, c_neuron_index=0, c_synapse_index=0, c_accumulate=0.
- Input handshake is combinational: input_ack = input_occurred & (state is RUN or ACCUM) & FIFO not full. The event is pushed in the same cycle. The requester holds input_occurred and input_index stable until ack and drops the request the cycle after ack. input_ack=0 in IDLE, UPDATE and DONE.
- Fire: output_occurred = fire & (state==UPDATE); output_index = c_neuron_index. Each firing pushes source id REC_BASE+n. These recurrent events are processed in the next timestep.
- Recurrent push with FIFO full: event dropped, overflow set to 1. External pushes cannot occur in UPDATE, so no same-cycle push conflict exists.
- Pop and push in the same cycle are both legal; count unchanged.
- step: sets step_pending in RUN, ACCUM or UPDATE. Because pending is cleared on UPDATE entry, a step during UPDATE arms the next timestep. step is ignored in IDLE and DONE. Multiple steps before UPDATE count as one.
- start is ignored in RUN, ACCUM and UPDATE.
- Reset asserted mid-sweep: immediate return to reset values. Any partial SRAM writes are not undone.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an occupancy count.

Test Plan:
- Reset then start, no inputs, step at cycle 5 -> UPDATE for 16 cycles: c_neuron_we=1, c_accumulate=0, index 0..15. Then time_count=1 and state is RUN. Before start, all outputs are 0.
- input_index=5 held one cycle in RUN (cycle t) -> input_ack=1 at t. ACCUM runs cycles t+2..t+17 with c_synapse_index=5, c_accumulate=1 and neuron index 0..15.
- 20 back-to-back requests with ids 0..19 -> exactly 16+1 accepted while the first sweep runs. input_ack is low whenever count=16. ACCUM sweeps occur in id order with no loss.
- fire=1 when c_neuron_index=3 in UPDATE -> output_occurred=1, output_index=3. The next sweep is ACCUM with c_synapse_index=16371. Forcing fire on all 16 with FIFO_DEPTH=8 -> 8 events kept, overflow=1.
- MAX_NETWORK_TIME=4 and 4 steps -> done=1, busy=0, time_count=0 (wrapped value), input_ack stays 0. A new start -> RUN with overflow cleared.
- reset driven low at neuron 7 of ACCUM with 3 events queued -> all outputs 0 in the same cycle. After release, state is IDLE with FIFO empty and start is required.
